ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4, meaning number of client ports (2..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning address bits per port.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning data bits; multiple of 8; BYTE_COUNT = DATA_WIDTH/8.
REQ-004 SHALL have parameter ARB_MODE, default ARB_ROUND_ROBIN, meaning arbitration policy (ARB_ROUND_ROBIN or ARB_FIXED_PRIO, index 0 highest).
REQ-005 SHALL have clk, input, 1, meaning single clock for all ports.
REQ-006 SHALL have reset, input, 1, meaning reset, asynchronous, active-high.
REQ-007 SHALL have c_en, input, NUM_CLIENTS, meaning per-client request enable.
REQ-008 SHALL have c_addr, input, NUM_CLIENTS*ADDR_WIDTH, meaning per-client address, client i at slice i.
REQ-009 SHALL have c_data_w, input, NUM_CLIENTS*DATA_WIDTH, meaning per-client write data.
REQ-010 SHALL have c_we, input, NUM_CLIENTS, meaning per-client write enable.
REQ-011 SHALL have c_be, input, NUM_CLIENTS*BYTE_COUNT, meaning per-client byte enables.
REQ-012 SHALL have c_data_r, output, NUM_CLIENTS*DATA_WIDTH, meaning per-client read data.
REQ-013 SHALL have c_delay, output, NUM_CLIENTS, meaning request of this cycle not accepted; client holds request.
REQ-014 SHALL have m_en, m_addr, m_data_w, m_we, m_be, outputs, widths 1/ADDR_WIDTH/DATA_WIDTH/1/BYTE_COUNT, meaning request to the single memory.
REQ-015 SHALL have m_data_r, input, DATA_WIDTH, and m_delay, input, 1, meaning memory read data and memory stall.

Function
REQ-016 SHALL select at most one granted client per cycle among clients with c_en=1; grant is combinational from current requests and state.
REQ-017 SHALL, in ARB_FIXED_PRIO, grant the lowest requesting index.
REQ-018 SHALL, in ARB_ROUND_ROBIN, grant the first requester at or after rr_ptr, wrapping NUM_CLIENTS-1 -> 0.
REQ-019 SHALL forward the granted client's addr, data_w, we, be to the memory port with m_en=1; with no request, m_en=0, m_we=0, m_be=0.
REQ-020 SHALL drive c_delay[i]=1 when c_en[i]=1 and i is not granted, or i is granted and m_delay=1; else 0.
REQ-021 SHALL treat a transfer as accepted when m_en=1 and m_delay=0 in the same cycle.
REQ-022 SHALL, while m_delay=1 with m_en=1, lock the grant to the same client in following cycles until acceptance, ignoring higher-priority requests.
REQ-023 SHALL, on acceptance in ROUND_ROBIN, load rr_ptr with (granted index + 1) mod NUM_CLIENTS; rr_ptr unchanged otherwise.
REQ-024 SHALL register the owner of each accepted read (we=0) in rsp_owner with rsp_valid=1, for exactly the following cycle.
REQ-025 SHALL drive c_data_r[rsp_owner]=m_data_r when rsp_valid=1; all other c_data_r slices, and all when rsp_valid=0, SHALL be zero.
REQ-026 SHALL sustain one accepted transfer per cycle; back-to-back reads from different clients each return data in the cycle after acceptance.
REQ-027 SHALL clear lock if the locked client drops c_en (protocol violation); arbitration resumes same cycle.

Reset
REQ-028 SHALL, on reset=1, asynchronously set rr_ptr=0, lock=0, rsp_valid=0, rsp_owner=0.
REQ-029 SHALL hold m_en=0, all c_delay=1 for requesting clients, and all c_data_r=0 while reset=1.
REQ-030 SHALL, on reset mid-transfer, drop the in-flight transfer with no response delivered after reset release.

Structure
REQ-031 SHALL place ARB_MODE enum (ARB_ROUND_ROBIN, ARB_FIXED_PRIO) in shared package ram_arb_pkg.
REQ-032 SHALL implement grant selection in one combinational sub-module ram_arb_pick (requests, start pointer -> one-hot grant, index).
REQ-033 SHALL keep rr_ptr width $clog2(NUM_CLIENTS), minimum 1.

Verification
REQ-034 SHALL test: RR, N=4, all c_en=1, m_delay=0 for 8 cycles -> grants 0,1,2,3,0,1,2,3; three c_delay high each cycle.
REQ-035 SHALL test: client 2 read addr 0x10, memory returns 0xCAFEF00D next cycle -> c_data_r slice 2 = 0xCAFEF00D, others 0.
REQ-036 SHALL test: client 1 granted, m_delay=1 three cycles while client 0 requests -> grant stays 1; client 1 accepted cycle 4, client 0 granted cycle 5.
REQ-037 SHALL test: FIXED_PRIO, clients 0 and 3 request continuously -> client 3 never granted, c_delay[3]=1 throughout.
REQ-038 SHALL test: reset asserted during a delayed read -> m_en=0 immediately, rr_ptr=0, no c_data_r nonzero after release.
REQ-039 SHALL test: client 3 write be=4'b0101, then client 0 read same addr -> m_be=0101 in write cycle, read data routed only to client 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the multi-client RAM arbiter.
package ram_arb_pkg;

  // Arbitration policy selector.
  typedef enum logic [0:0] {
    ARB_ROUND_ROBIN = 1'b0,
    ARB_FIXED_PRIO  = 1'b1
  } arb_mode_e;

  // Width of a client index / round-robin pointer, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant picker: first requester at or after 'start', wrapping.
// With start tied to zero it degenerates to fixed priority (index 0 highest).
module ram_arb_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] at_or_after;
  logic [N-1:0] masked;
  logic [N-1:0] pool;

  // Mask of positions that come no earlier than the start pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign at_or_after[gi] = (PTR_W'(gi) >= start);
  end

  // Prefer requesters from start upward; if none, wrap to the low indices.
  assign masked = req & at_or_after;
  assign pool   = (|masked) ? masked : req;

  // Isolate the lowest set bit of the candidate pool.
  assign grant = pool & (~pool + ONE);

  // Encode the one-hot grant into an index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// N-client arbiter in front of a single-ported memory. Grants one client per
// cycle, holds the grant while the memory stalls, and routes read data back
// to the client whose read was accepted in the previous cycle.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int        NUM_CLIENTS = 4,
  parameter int        ADDR_WIDTH  = 32,
  parameter int        DATA_WIDTH  = 32,
  parameter arb_mode_e ARB_MODE    = ARB_ROUND_ROBIN,
  localparam int       BYTE_COUNT  = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            c_en,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_data_w,
  input  logic [NUM_CLIENTS-1:0]            c_we,
  input  logic [NUM_CLIENTS*BYTE_COUNT-1:0] c_be,
  output logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_data_r,
  output logic [NUM_CLIENTS-1:0]            c_delay,
  output logic                              m_en,
  output logic [ADDR_WIDTH-1:0]             m_addr,
  output logic [DATA_WIDTH-1:0]             m_data_w,
  output logic                              m_we,
  output logic [BYTE_COUNT-1:0]             m_be,
  input  logic [DATA_WIDTH-1:0]             m_data_r,
  input  logic                              m_delay
);

  localparam int PTR_W = ptr_width(NUM_CLIENTS);

  logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next;
  logic                   lock_reg, lock_next;
  logic [PTR_W-1:0]       lock_idx_reg, lock_idx_next;
  logic                   rsp_valid_reg, rsp_valid_next;
  logic [PTR_W-1:0]       rsp_owner_reg, rsp_owner_next;

  logic [PTR_W-1:0]       pick_start;
  logic [NUM_CLIENTS-1:0] pick_grant;
  logic [PTR_W-1:0]       pick_idx;
  logic [NUM_CLIENTS-1:0] lock_onehot;
  logic                   lock_hit;
  logic [NUM_CLIENTS-1:0] grant;
  logic [PTR_W-1:0]       grant_idx;
  logic                   accept;

  // Fixed priority always scans from client 0.
  assign pick_start = (ARB_MODE == ARB_FIXED_PRIO) ? '0 : rr_ptr_reg;

  ram_arb_pick #(
    .N     (NUM_CLIENTS),
    .PTR_W (PTR_W)
  ) u_pick (
    .req       (c_en),
    .start     (pick_start),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_lock
    assign lock_onehot[gi] = (lock_idx_reg == PTR_W'(gi));
  end

  // A lock only holds while its owner still requests; a dropped request
  // releases it and normal arbitration takes over in the same cycle.
  assign lock_hit  = lock_reg && |(lock_onehot & c_en);
  assign grant     = reset ? '0 : (lock_hit ? lock_onehot : pick_grant);
  assign grant_idx = lock_hit ? lock_idx_reg : pick_idx;
  assign m_en      = |grant;
  assign accept    = m_en && !m_delay;

  // Forward the granted client's request fields; idle port drives zeros.
  always_comb begin
    m_addr   = '0;
    m_data_w = '0;
    m_we     = 1'b0;
    m_be     = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant[i]) begin
        m_addr   = c_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_data_w = c_data_w[i*DATA_WIDTH +: DATA_WIDTH];
        m_we     = c_we[i];
        m_be     = c_be[i*BYTE_COUNT +: BYTE_COUNT];
      end
    end
  end

  // Per-client stall and read-data routing.
  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
    assign c_delay[gi] = c_en[gi] && (!grant[gi] || m_delay);
    assign c_data_r[gi*DATA_WIDTH +: DATA_WIDTH] =
      (rsp_valid_reg && rsp_owner_reg == PTR_W'(gi)) ? m_data_r : '0;
  end

  // Next-state: lock on stall, advance pointer and record read owner on acceptance.
  always_comb begin
    rr_ptr_next    = rr_ptr_reg;
    lock_next      = 1'b0;
    lock_idx_next  = lock_idx_reg;
    rsp_valid_next = 1'b0;
    rsp_owner_next = rsp_owner_reg;
    if (m_en && m_delay) begin
      lock_next     = 1'b1;
      lock_idx_next = grant_idx;
    end
    if (accept) begin
      if (ARB_MODE == ARB_ROUND_ROBIN) begin
        rr_ptr_next = (grant_idx == PTR_W'(NUM_CLIENTS - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      if (!m_we) begin
        rsp_valid_next = 1'b1;
        rsp_owner_next = grant_idx;
      end
    end
  end

  // State registers; reset discards any in-flight transfer and its response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg    <= '0;
      lock_reg      <= 1'b0;
      lock_idx_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_owner_reg <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      lock_reg      <= lock_next;
      lock_idx_reg  <= lock_idx_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_owner_reg <= rsp_owner_next;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin and a fixed-priority instance share
// one stimulus stream and are both compared every cycle against a
// transaction-level model; directed sequences add literal expectations.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BC = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   c_en;
  logic [NC*AW-1:0] c_addr;
  logic [NC*DW-1:0] c_data_w;
  logic [NC-1:0]   c_we;
  logic [NC*BC-1:0] c_be;
  logic [DW-1:0]   m_data_r;
  logic            m_delay;

  logic [NC*DW-1:0] c_data_r_o [2];
  logic [NC-1:0]    c_delay_o  [2];
  logic             m_en_o     [2];
  logic [AW-1:0]    m_addr_o   [2];
  logic [DW-1:0]    m_data_w_o [2];
  logic             m_we_o     [2];
  logic [BC-1:0]    m_be_o     [2];

  int n_vec = 0;
  int n_err = 0;

  // Model state per instance: next RR start, locked client, pending read owner (-1 = none).
  int mdl_ptr  [2] = '{0, 0};
  int mdl_lock [2] = '{-1, -1};
  int mdl_rsp  [2] = '{-1, -1};

  always #5 clk = ~clk;

  ram_arbiter #(.NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(ARB_ROUND_ROBIN)) u_rr (
    .clk(clk), .reset(reset), .c_en(c_en), .c_addr(c_addr), .c_data_w(c_data_w),
    .c_we(c_we), .c_be(c_be), .c_data_r(c_data_r_o[0]), .c_delay(c_delay_o[0]),
    .m_en(m_en_o[0]), .m_addr(m_addr_o[0]), .m_data_w(m_data_w_o[0]), .m_we(m_we_o[0]),
    .m_be(m_be_o[0]), .m_data_r(m_data_r), .m_delay(m_delay)
  );

  ram_arbiter #(.NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(ARB_FIXED_PRIO)) u_fp (
    .clk(clk), .reset(reset), .c_en(c_en), .c_addr(c_addr), .c_data_w(c_data_w),
    .c_we(c_we), .c_be(c_be), .c_data_r(c_data_r_o[1]), .c_delay(c_delay_o[1]),
    .m_en(m_en_o[1]), .m_addr(m_addr_o[1]), .m_data_w(m_data_w_o[1]), .m_we(m_we_o[1]),
    .m_be(m_be_o[1]), .m_data_r(m_data_r), .m_delay(m_delay)
  );

  function automatic string dn(input int d);
    return (d == 0) ? "rr" : "fp";
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Which client the arbitration rules select this cycle (-1 = none).
  function automatic int model_grant(input int d);
    int start;
    int j;
    if (reset) return -1;
    if (mdl_lock[d] >= 0 && c_en[mdl_lock[d]]) return mdl_lock[d];
    start = (d == 1) ? 0 : mdl_ptr[d];
    for (int k = 0; k < NC; k++) begin
      j = (start + k) % NC;
      if (c_en[j]) return j;
    end
    return -1;
  endfunction

  // Every-cycle comparison against the model, then model state advance.
  initial begin : compare_proc
    int g;
    int glog [2];
    logic [127:0] exp_r;
    logic [NC-1:0] exp_dly;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        g = model_grant(d);
        glog[d] = g;
        exp_r = '0;
        if (!reset && mdl_rsp[d] >= 0) exp_r[mdl_rsp[d]*DW +: DW] = m_data_r;
        for (int i = 0; i < NC; i++) exp_dly[i] = c_en[i] && (i != g || m_delay);
        chk({dn(d), ".m_en"}, m_en_o[d], g >= 0);
        if (g >= 0) begin
          chk({dn(d), ".m_addr"}, m_addr_o[d], c_addr[g*AW +: AW]);
          chk({dn(d), ".m_data_w"}, m_data_w_o[d], c_data_w[g*DW +: DW]);
          chk({dn(d), ".m_we"}, m_we_o[d], c_we[g]);
          chk({dn(d), ".m_be"}, m_be_o[d], c_be[g*BC +: BC]);
        end else begin
          chk({dn(d), ".m_we_idle"}, m_we_o[d], 0);
          chk({dn(d), ".m_be_idle"}, m_be_o[d], 0);
        end
        chk({dn(d), ".c_delay"}, c_delay_o[d], exp_dly);
        chk({dn(d), ".c_data_r"}, c_data_r_o[d], exp_r);
        if (reset) begin
          mdl_ptr[d] = 0; mdl_lock[d] = -1; mdl_rsp[d] = -1;
        end else begin
          mdl_lock[d] = -1;
          mdl_rsp[d]  = -1;
          if (g >= 0) begin
            if (m_delay) mdl_lock[d] = g;
            else begin
              if (!c_we[g]) mdl_rsp[d] = g;
              if (d == 0) mdl_ptr[d] = (g + 1) % NC;
            end
          end
        end
      end
      $display("cycle @%0t rst=%0b en=%b dly=%0b rr_grant=%0d fp_grant=%0d",
               $time, reset, c_en, m_delay, glog[0], glog[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_grant(input int d, input int g, input string tag);
    chk({dn(d), ".", tag, ".m_en"}, m_en_o[d], 1'b1);
    chk({dn(d), ".", tag, ".m_addr"}, m_addr_o[d], 32'h100 + 32'(4 * g));
  endtask

  task automatic default_fields();
    for (int i = 0; i < NC; i++) begin
      c_addr[i*AW +: AW]   = 32'h100 + 32'(4 * i);
      c_data_w[i*DW +: DW] = 32'hD0 + 32'(i);
    end
    c_be = '1;
    c_we = '0;
  endtask

  initial begin : drive_proc
    reset = 1'b1; c_en = 4'hF; m_data_r = '0; m_delay = 1'b0;
    default_fields();

    // Reset state: nothing granted, every requester stalled, no read data.
    step(); settle();
    for (int d = 0; d < 2; d++) begin
      chk({dn(d), ".rst_m_en"}, m_en_o[d], 1'b0);
      chk({dn(d), ".rst_c_delay"}, c_delay_o[d], 4'hF);
      chk({dn(d), ".rst_c_data_r"}, c_data_r_o[d], '0);
    end
    step();

    // Round robin with everyone requesting: 0,1,2,3,0,1,2,3.
    step(); reset = 1'b0; c_en = 4'hF; m_delay = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      settle();
      chk_grant(0, k % 4, "rr_seq");
      chk("rr.rr_seq.delay_count", $countones(c_delay_o[0]), 3);
    end

    // Client 2 read of 0x10; data returns to slice 2 only.
    step(); c_en = 4'b0100; c_addr[2*AW +: AW] = 32'h10;
    settle();
    chk("rr.rd2.m_addr", m_addr_o[0], 32'h10);
    step(); c_en = 4'b0000; m_data_r = 32'hCAFEF00D;
    settle();
    for (int d = 0; d < 2; d++)
      chk({dn(d), ".rd2.c_data_r"}, c_data_r_o[d], 128'h00000000_CAFEF00D_00000000_00000000);
    step(); m_data_r = '0; default_fields();

    // Stall lock: client 1 holds the grant through three stalled cycles.
    step(); c_en = 4'b0010; m_delay = 1'b1;
    settle();
    for (int d = 0; d < 2; d++) chk_grant(d, 1, "lock_c1");
    for (int k = 0; k < 3; k++) begin
      step(); c_en = 4'b0011; m_delay = (k < 2);
      settle();
      for (int d = 0; d < 2; d++) begin
        chk_grant(d, 1, "lock_hold");
        chk({dn(d), ".lock_hold.c_delay0"}, c_delay_o[d][0], 1'b1);
      end
    end
    step(); c_en = 4'b0001; m_delay = 1'b0;
    settle();
    for (int d = 0; d < 2; d++) chk_grant(d, 0, "after_lock");

    // Fixed priority starvation of client 3 by client 0.
    for (int k = 0; k < 12; k++) begin
      step(); c_en = 4'b1001; m_delay = ($urandom_range(0, 1) == 1);
      settle();
      chk("fp.starve.m_addr", m_addr_o[1], 32'h100);
      chk("fp.starve.c_delay3", c_delay_o[1][3], 1'b1);
    end

    // Reset during a stalled read: idle at once, no late response, pointer back to 0.
    step(); c_en = 4'b0100; m_delay = 1'b0;
    step(); m_delay = 1'b1;
    step();
    step(); reset = 1'b1;
    settle();
    for (int d = 0; d < 2; d++) begin
      chk({dn(d), ".rst_mid.m_en"}, m_en_o[d], 1'b0);
      chk({dn(d), ".rst_mid.c_delay"}, c_delay_o[d], 4'b0100);
      chk({dn(d), ".rst_mid.c_data_r"}, c_data_r_o[d], '0);
    end
    step();
    step(); reset = 1'b0; c_en = 4'b0000; m_delay = 1'b0; m_data_r = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      settle();
      for (int d = 0; d < 2; d++) chk({dn(d), ".post_rst.c_data_r"}, c_data_r_o[d], '0);
    end
    step(); c_en = 4'hF;
    settle();
    chk_grant(0, 0, "post_rst_ptr");
    step(); c_en = 4'h0; m_data_r = '0;

    // Byte-enabled write by client 3, then read of the same address by client 0.
    step(); c_en = 4'b1000; c_we = 4'b1000; c_addr[3*AW +: AW] = 32'h40;
    c_data_w[3*DW +: DW] = 32'hAABBCCDD; c_be[3*BC +: BC] = 4'b0101;
    settle();
    for (int d = 0; d < 2; d++) begin
      chk({dn(d), ".wr3.m_be"}, m_be_o[d], 4'b0101);
      chk({dn(d), ".wr3.m_we"}, m_we_o[d], 1'b1);
      chk({dn(d), ".wr3.m_addr"}, m_addr_o[d], 32'h40);
      chk({dn(d), ".wr3.m_data_w"}, m_data_w_o[d], 32'hAABBCCDD);
    end
    step(); c_en = 4'b0001; c_we = 4'b0000; c_addr[0 +: AW] = 32'h40;
    settle();
    for (int d = 0; d < 2; d++) begin
      chk({dn(d), ".rd0.m_addr"}, m_addr_o[d], 32'h40);
      chk({dn(d), ".rd0.m_we"}, m_we_o[d], 1'b0);
    end
    step(); c_en = 4'b0000; m_data_r = 32'h00BB00DD;
    settle();
    for (int d = 0; d < 2; d++)
      chk({dn(d), ".rd0.c_data_r"}, c_data_r_o[d], 128'h00BB00DD);
    step(); m_data_r = '0; default_fields();

    // Randomized traffic, stalls, request drops and occasional resets.
    for (int k = 0; k < 400; k++) begin
      step();
      reset    = ($urandom_range(0, 59) == 0);
      c_en     = 4'($urandom);
      c_we     = 4'($urandom);
      c_be     = 16'($urandom);
      for (int i = 0; i < NC; i++) begin
        c_addr[i*AW +: AW]   = $urandom;
        c_data_w[i*DW +: DW] = $urandom;
      end
      m_delay  = ($urandom_range(0, 2) == 0);
      m_data_r = $urandom;
    end
    step();
    reset = 1'b0; c_en = '0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
